// File: rtl/peripheral_ahb3_verilog_pkg.sv
// AHB3-Lite encodings shared by the bench peripherals.
package peripheral_ahb3_verilog_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

endpackage

// File: rtl/pu_riscv_mmio_host_pkg.sv
// Register map, FSM states and byte-lane helper for the host MMIO window.
package pu_riscv_mmio_host_pkg;
  import peripheral_ahb3_verilog_pkg::*;

  localparam logic [7:0] OFF_TEST     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_WATCHDOG = 8'h08;
  localparam logic [7:0] OFF_UART     = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } host_state_e;

  // Little-endian byte enables for an access of 'size' at byte offset 'addr_lo'.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] addr_lo,
                                           input int unsigned nbytes);
    logic [7:0] base;
    logic [7:0] valid;
    logic [2:0] sh;
    case (size)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HWORD: base = 8'h03;
      HSIZE_WORD:  base = 8'h0f;
      HSIZE_DWORD: base = 8'hff;
      default:     base = 8'hff;
    endcase
    sh    = addr_lo & 3'(nbytes - 1);
    valid = (nbytes >= 8) ? 8'hff : 8'((32'd1 << nbytes) - 32'd1);
    return (base << sh) & valid;
  endfunction

endpackage

// File: rtl/pu_riscv_mmio_host_report.sv
// Sticky done/pass latch, cycle watchdog and end-of-test banner.
module pu_riscv_mmio_host_report #(
  parameter int unsigned HDATA_SIZE     = 32,
  parameter int unsigned WATCHDOG_LIMIT = 1_000_000,
  parameter bit          FINISH_ON_DONE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_we_i,
  input  logic [HDATA_SIZE-1:0] test_wdata_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [HDATA_SIZE-1:0] wdog_o
);

  localparam logic [HDATA_SIZE-1:0] Limit = HDATA_SIZE'(WATCHDOG_LIMIT);
  localparam logic [HDATA_SIZE-1:0] One   = HDATA_SIZE'(1);

  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [HDATA_SIZE-1:0] wdog_q, wdog_d;
  logic                  test_fin, timeout;

  always_comb begin
    wdog_d = wdog_q;
    if (!done_q && (wdog_q < Limit)) wdog_d = wdog_q + One;
    test_fin = test_we_i && !done_q && test_wdata_i[0];
    // A finishing TEST write in the limit cycle takes precedence over the timeout.
    timeout  = !done_q && !test_fin && (wdog_d == Limit);
    done_d   = done_q | test_fin | timeout;
    pass_d   = pass_q;
    if (test_fin)     pass_d = (test_wdata_i == One);
    else if (timeout) pass_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      wdog_q <= '0;
    end else begin
      done_q <= done_d;
      pass_q <= pass_d;
      wdog_q <= wdog_d;
      if (test_fin) begin
        if (test_wdata_i == One) $display("*** TEST PASSED (code 0x%0h) ***", test_wdata_i >> 1);
        else                     $display("*** test failed, code 0x%0h ***", test_wdata_i >> 1);
      end
      if (timeout) $display("*** watchdog timeout after %0d cycles ***", wdog_d);
      if ((test_fin || timeout) && FINISH_ON_DONE) $finish;
    end
  end

  assign done_o = done_q;
  assign pass_o = pass_q;
  assign wdog_o = wdog_q;

endmodule

// File: rtl/pu_riscv_mmio_host_ahb3.sv
// AHB3-Lite host MMIO window: TEST/STATUS/WATCHDOG registers and UART TX consoles.
module pu_riscv_mmio_host_ahb3
  import peripheral_ahb3_verilog_pkg::*;
  import pu_riscv_mmio_host_pkg::*;
#(
  parameter int unsigned           HDATA_SIZE     = 32,
  parameter int unsigned           HADDR_SIZE     = 32,
  parameter logic [HADDR_SIZE-1:0] BASE_ADDR      = 'h8000_1000,
  parameter int unsigned           UART_CHANNELS  = 1,
  parameter int unsigned           WAIT_STATES    = 0,
  parameter int unsigned           WATCHDOG_LIMIT = 1_000_000,
  parameter bit                    FINISH_ON_DONE = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  test_done,
  output logic                  test_pass,
  output logic [HDATA_SIZE-1:0] test_code
);

  localparam int unsigned NBytes   = HDATA_SIZE / 8;
  localparam int unsigned LaneBits = $clog2(NBytes);
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  host_state_e state_q, state_d, entry_state;
  logic [7:0]  off_q, off_d;
  logic        write_q, write_d, hit_q, hit_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  wcnt_q, wcnt_d;

  logic                     htrans_active, accept, in_window, hit_addr;
  logic [7:0]               reg_off, bmask, uart_byte;
  logic [2:0]               uart_ch;
  logic                     data_phase, test_we, uart_we, uart_bol;
  logic [HDATA_SIZE-1:0]    wmask, test_merged, test_code_q, test_code_d, wdog;
  logic [UART_CHANNELS-1:0] bol_q, bol_d;
  logic                     unused_hburst;

  assign unused_hburst = ^HBURST;

  // SEQ is handled exactly like NONSEQ; bursts are not tracked.
  assign htrans_active = !(HTRANS inside {HTRANS_IDLE, HTRANS_BUSY});
  assign accept        = HSEL && HREADY && htrans_active;
  assign in_window     = (HADDR[HADDR_SIZE-1:8] == BASE_ADDR[HADDR_SIZE-1:8]);

  always_comb begin
    hit_addr = 1'b0;
    if (in_window) begin
      if ({HADDR[7:2], 2'b00} inside {OFF_TEST, OFF_STATUS, OFF_WATCHDOG}) begin
        hit_addr = 1'b1;
      end else if ((HADDR[7:5] == OFF_UART[7:5]) && (32'(HADDR[4:2]) < UART_CHANNELS)) begin
        hit_addr = 1'b1;
      end
    end
    if (WAIT_STATES > 0) entry_state = StWait;
    else                 entry_state = hit_addr ? StData : StErr1;
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    off_d     = off_q;
    write_d   = write_q;
    size_d    = size_q;
    hit_d     = hit_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (state_q)
      StWait: begin
        HREADYOUT = 1'b0;
        if (wcnt_q == 4'd0) state_d = hit_q ? StData : StErr1;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      StErr1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = StErr2;
      end
      default: begin
        // Idle, Data and Err2 all end with HREADYOUT high, so each can take a new address phase.
        if (state_q == StErr2) HRESP = HRESP_ERROR;
        state_d = StIdle;
        if (accept) begin
          state_d = entry_state;
          wcnt_d  = WaitLoad;
          off_d   = HADDR[7:0];
          write_d = HWRITE;
          size_d  = HSIZE;
          hit_d   = hit_addr;
        end
      end
    endcase
  end

  assign data_phase  = (state_q == StData);
  assign reg_off     = {off_q[7:2], 2'b00};
  assign bmask       = lane_mask(size_q, off_q[2:0], NBytes);
  assign test_we     = data_phase && write_q && (reg_off == OFF_TEST);
  assign test_merged = (test_code_q & ~wmask) | (HWDATA & wmask);
  assign test_code_d = (test_we && !test_done) ? test_merged : test_code_q;
  assign uart_we     = data_phase && write_q && (off_q[7:5] == OFF_UART[7:5]);
  assign uart_ch     = off_q[4:2];
  assign uart_byte   = 8'(HWDATA >> {off_q[LaneBits-1:0], 3'b000});

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < NBytes; i++) wmask[8*i +: 8] = {8{bmask[i]}};
  end

  always_comb begin
    HRDATA = '0;
    if (data_phase && !write_q) begin
      case (reg_off)
        OFF_TEST:     HRDATA = test_code_q;
        OFF_STATUS:   HRDATA = {wdog[HDATA_SIZE-3:0], test_pass, test_done};
        OFF_WATCHDOG: HRDATA = wdog;
        default:      HRDATA = '0;
      endcase
    end
  end

  // Per-channel beginning-of-line flag drives the "[chN] " prefix.
  always_comb begin
    bol_d    = bol_q;
    uart_bol = 1'b0;
    for (int unsigned i = 0; i < UART_CHANNELS; i++) begin
      if (32'(uart_ch) == i) begin
        uart_bol = bol_q[i];
        if (uart_we) bol_d[i] = (uart_byte == 8'h0a);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      off_q       <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      hit_q       <= 1'b0;
      test_code_q <= '0;
      bol_q       <= '1;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      off_q       <= off_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hit_q       <= hit_d;
      test_code_q <= test_code_d;
      bol_q       <= bol_d;
      if (uart_we) begin
        if ((UART_CHANNELS > 1) && uart_bol) $write("[ch%0d] ", uart_ch);
        $write("%c", uart_byte);
      end
    end
  end

  assign test_code = test_code_q;

  pu_riscv_mmio_host_report #(
    .HDATA_SIZE     (HDATA_SIZE),
    .WATCHDOG_LIMIT (WATCHDOG_LIMIT),
    .FINISH_ON_DONE (FINISH_ON_DONE)
  ) u_report (
    .clk_i        (HCLK),
    .rst_ni       (HRESETn),
    .test_we_i    (test_we),
    .test_wdata_i (test_merged),
    .done_o       (test_done),
    .pass_o       (test_pass),
    .wdog_o       (wdog)
  );

endmodule

// File: tb/tb_pu_riscv_mmio_host_ahb3.sv
// Directed bench: dut_a has 3 wait states and a 100-cycle watchdog, dut_b has none.
module tb_pu_riscv_mmio_host_ahb3;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        sel = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;

  logic [31:0] hrdata_a, hrdata_b, code_a, code_b;
  logic        hreadyout_a, hreadyout_b, hresp_a, hresp_b;
  logic        done_a, done_b, pass_a, pass_b;
  logic        hsel_a, hsel_b, hready_m, hresp_m;
  logic [31:0] hrdata_m;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] Base = 32'h8000_1000;

  always #5 hclk = ~hclk;

  assign hsel_a   = hsel && !sel;
  assign hsel_b   = hsel && sel;
  assign hready_m = sel ? hreadyout_b : hreadyout_a;
  assign hresp_m  = sel ? hresp_b : hresp_a;
  assign hrdata_m = sel ? hrdata_b : hrdata_a;

  pu_riscv_mmio_host_ahb3 #(
    .HDATA_SIZE(32), .HADDR_SIZE(32), .BASE_ADDR(32'h8000_1000), .UART_CHANNELS(1),
    .WAIT_STATES(3), .WATCHDOG_LIMIT(100), .FINISH_ON_DONE(1'b0)
  ) dut_a (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_a), .HTRANS(htrans), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready_m),
    .HRDATA(hrdata_a), .HREADYOUT(hreadyout_a), .HRESP(hresp_a),
    .test_done(done_a), .test_pass(pass_a), .test_code(code_a)
  );

  pu_riscv_mmio_host_ahb3 #(
    .HDATA_SIZE(32), .HADDR_SIZE(32), .BASE_ADDR(32'h8000_1000), .UART_CHANNELS(2),
    .WAIT_STATES(0), .WATCHDOG_LIMIT(100_000), .FINISH_ON_DONE(1'b0)
  ) dut_b (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_b), .HTRANS(htrans), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready_m),
    .HRDATA(hrdata_b), .HREADYOUT(hreadyout_b), .HRESP(hresp_b),
    .test_done(done_b), .test_pass(pass_b), .test_code(code_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    hsel    = 1'b0;
    htrans  = 2'b00;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
  endtask

  // Single transfer; starts and ends 1 time unit after a rising edge.
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic resp, output int waits);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    waits = 0;
    resp  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge hclk);
      if (hresp_m) resp = 1'b1;
      if (hready_m) break;
      waits++;
    end
    if (!hready_m) check_eq("xfer_timeout", 64'(hready_m), 64'd1);
    rdata = hrdata_m;
    @(posedge hclk);
    #1;
  endtask

  logic [31:0] rd;
  logic        rsp;
  int          nw;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge hclk);
    #1;
    check_eq("rst_hreadyout_a", 64'(hreadyout_a), 64'd1);
    check_eq("rst_hresp_a", 64'(hresp_a), 64'd0);
    check_eq("rst_hrdata_a", 64'(hrdata_a), 64'd0);
    check_eq("rst_done_a", 64'(done_a), 64'd0);
    check_eq("rst_pass_a", 64'(pass_a), 64'd0);
    check_eq("rst_code_a", 64'(code_a), 64'd0);
    check_eq("rst_hreadyout_b", 64'(hreadyout_b), 64'd1);
    hresetn = 1'b1;

    // dut_b: back-to-back write then read of TEST
    sel = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = Base; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk);
    #1;
    hwrite = 1'b0; hwdata = 32'h10;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    check_eq("b2b_ready", 64'(hreadyout_b), 64'd1);
    check_eq("b2b_rdata", 64'(hrdata_b), 64'h10);
    @(posedge hclk);
    #1;
    check_eq("b2b_code", 64'(code_b), 64'h10);
    check_eq("b2b_not_done", 64'(done_b), 64'd0);

    ahb_xfer(1'b1, Base + 32'h84, 3'd0, 32'h48, rd, rsp, nw);
    check_eq("ws0_uart_waits", 64'(nw), 64'd0);
    ahb_xfer(1'b1, Base + 32'h84, 3'd0, 32'h0a, rd, rsp, nw);
    ahb_xfer(1'b1, Base, 3'd2, 32'h1, rd, rsp, nw);
    check_eq("ws0_pass_waits", 64'(nw), 64'd0);
    check_eq("ws0_pass_resp", 64'(rsp), 64'd0);
    check_eq("ws0_done", 64'(done_b), 64'd1);
    check_eq("ws0_pass", 64'(pass_b), 64'd1);
    check_eq("ws0_code", 64'(code_b), 64'd1);

    // dut_a: wait states, byte lanes, error responses
    sel = 1'b0;
    do_reset();
    ahb_xfer(1'b1, Base + 32'h80, 3'd2, 32'h41, rd, rsp, nw);
    check_eq("ws3_uart_waits", 64'(nw), 64'd3);
    check_eq("ws3_uart_resp", 64'(rsp), 64'd0);
    ahb_xfer(1'b1, Base + 32'h80, 3'd2, 32'h0a, rd, rsp, nw);
    ahb_xfer(1'b1, Base + 32'h2, 3'd0, 32'h00AB_0000, rd, rsp, nw);
    check_eq("byte_wr_waits", 64'(nw), 64'd3);
    ahb_xfer(1'b0, Base, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("byte_lane_rd", 64'(rd), 64'h00AB_0000);
    check_eq("byte_lane_done", 64'(done_a), 64'd0);
    ahb_xfer(1'b1, Base, 3'd1, 32'hFFFF_1234, rd, rsp, nw);
    check_eq("half_lane_code", 64'(code_a), 64'h00AB_1234);
    ahb_xfer(1'b0, Base + 32'h40, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("unmapped_rd_resp", 64'(rsp), 64'd1);
    check_eq("unmapped_rd_waits", 64'(nw), 64'd4);
    check_eq("unmapped_rd_data", 64'(rd), 64'd0);
    check_eq("post_err_ready", 64'(hreadyout_a), 64'd1);
    check_eq("post_err_resp", 64'(hresp_a), 64'd0);
    ahb_xfer(1'b1, Base + 32'h44, 3'd2, 32'hFFFF_FFFF, rd, rsp, nw);
    check_eq("unmapped_wr_resp", 64'(rsp), 64'd1);
    check_eq("unmapped_wr_code", 64'(code_a), 64'h00AB_1234);
    ahb_xfer(1'b0, 32'h8000_2000, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("out_window_resp", 64'(rsp), 64'd1);
    ahb_xfer(1'b1, Base + 32'h4, 3'd2, 32'h1, rd, rsp, nw);
    check_eq("ro_wr_resp", 64'(rsp), 64'd0);
    check_eq("ro_wr_done", 64'(done_a), 64'd0);
    ahb_xfer(1'b0, Base + 32'h80, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("uart_rd_data", 64'(rd), 64'd0);
    check_eq("uart_rd_resp", 64'(rsp), 64'd0);
    ahb_xfer(1'b0, Base + 32'h4, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("status_flags", 64'(rd[1:0]), 64'd0);

    // dut_a: watchdog expiry with no traffic
    do_reset();
    repeat (99) @(posedge hclk);
    #1;
    check_eq("wdog_99_done", 64'(done_a), 64'd0);
    @(posedge hclk);
    #1;
    check_eq("wdog_100_done", 64'(done_a), 64'd1);
    check_eq("wdog_100_pass", 64'(pass_a), 64'd0);
    ahb_xfer(1'b0, Base + 32'h4, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("wdog_status", 64'(rd), 64'h191);
    ahb_xfer(1'b0, Base + 32'h8, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("wdog_value", 64'(rd), 64'd100);
    ahb_xfer(1'b1, Base, 3'd2, 32'h1, rd, rsp, nw);
    check_eq("wdog_late_code", 64'(code_a), 64'd0);
    check_eq("wdog_late_pass", 64'(pass_a), 64'd0);

    // dut_a: failing code, then a later pass write must be ignored
    do_reset();
    ahb_xfer(1'b1, Base, 3'd2, 32'h7, rd, rsp, nw);
    check_eq("fail_done", 64'(done_a), 64'd1);
    check_eq("fail_pass", 64'(pass_a), 64'd0);
    check_eq("fail_code", 64'(code_a), 64'd7);
    ahb_xfer(1'b1, Base, 3'd2, 32'h1, rd, rsp, nw);
    check_eq("fail_sticky_pass", 64'(pass_a), 64'd0);
    check_eq("fail_sticky_code", 64'(code_a), 64'd7);
    ahb_xfer(1'b0, Base, 3'd2, 32'h0, rd, rsp, nw);
    check_eq("fail_test_rd", 64'(rd), 64'd7);

    $display("");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
